// File: rtl/countdown_timer_hms.sv
// Purpose : BCD HH:MM:SS countdown timer with validated load, pause/resume and expiry flag.
// Latency : every input is sampled on the rising clock; all outputs update one cycle later.
// Backpressure: none. Each cycle acts on at most one command (clear > load > pause > start > tick).
//
// Ports:
//   i_clk, i_rst_n       clock and asynchronous active-low reset
//   i_tick               one-cycle 1 Hz enable from the prescaler
//   i_load, i_load_time  load request and BCD start time {h_t,h_u,m_t,m_u,s_t,s_u}
//   i_start, i_pause     begin/resume counting and hold counting
//   i_clear              synchronous return to 00:00:00 / IDLE
//   o_time_out           current BCD time, packed the same way as i_load_time
//   o_running            high while counting
//   o_expired            high once the count has reached zero
//   o_done               one-cycle pulse when 00:00:00 is reached
//   o_load_err           one-cycle pulse when a load is rejected
// Optional: define COUNTDOWN_AUTO_RELOAD_EN to restart from the last valid load on expiry.
module countdown_timer_hms #(
    parameter bit H24 = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tick,
    input  logic        i_load,
    input  logic [23:0] i_load_time,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_clear,
    output logic [23:0] o_time_out,
    output logic        o_running,
    output logic        o_expired,
    output logic        o_done,
    output logic        o_load_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_time;
    logic [23:0] w_time_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_load_err;
    logic        w_load_err_nxt;
    logic        r_running;
    logic        r_expired;
    logic        w_load_ok;
    logic [23:0] w_time_dec;

    // Accepts a start time only if it is a legal clock reading.
    function automatic logic time_valid(input logic [23:0] t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        if (t[7:4] > 4'd5)   ok = 1'b0;   // s_t
        if (t[15:12] > 4'd5) ok = 1'b0;   // m_t
        if (H24) begin
            if (t[23:20] > 4'd2) ok = 1'b0;
            if (t[23:20] == 4'd2 && t[19:16] > 4'd3) ok = 1'b0;
        end
        return ok;
    endfunction

    // One-second decrement with the digit-to-digit borrow chain. The hour
    // tens digit never borrows out because counting never starts at zero.
    function automatic logic [23:0] time_dec(input logic [23:0] t);
        logic [23:0] r;
        logic        b;
        r = t;
        b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (b) begin
                if (t[i*4 +: 4] == 4'd0 && i != 5) begin
                    r[i*4 +: 4] = (i == 1 || i == 3) ? 4'd5 : 4'd9;
                    b = 1'b1;
                end else begin
                    r[i*4 +: 4] = t[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign w_load_ok  = time_valid(i_load_time);
    assign w_time_dec = time_dec(r_time);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [23:0] r_reload;
    logic [23:0] w_reload_nxt;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_time_nxt     = r_time;
        w_done_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        w_reload_nxt   = r_reload;
`endif
        if (i_clear) begin
            w_state_nxt = S_IDLE;
            w_time_nxt  = 24'h0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            w_reload_nxt = 24'h0;
`endif
        end else if (i_load) begin
            // A rejected load still owns the cycle: nothing else happens.
            if (w_load_ok) begin
                w_state_nxt = S_IDLE;
                w_time_nxt  = i_load_time;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                w_reload_nxt = i_load_time;
`endif
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if (i_pause) begin
            if (r_state == S_RUN) w_state_nxt = S_PAUSE;
        end else if (i_start) begin
            if ((r_state == S_IDLE && r_time != 24'h0) || r_state == S_PAUSE)
                w_state_nxt = S_RUN;
        end else if (i_tick && r_state == S_RUN) begin
            if (r_time == 24'h000001) begin
                w_done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (r_reload != 24'h0) begin
                    w_time_nxt = r_reload;
                end else begin
                    w_time_nxt  = 24'h0;
                    w_state_nxt = S_EXPIRED;
                end
`else
                w_time_nxt  = 24'h0;
                w_state_nxt = S_EXPIRED;
`endif
            end else begin
                w_time_nxt = w_time_dec;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_time     <= 24'h0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
            r_running  <= 1'b0;
            r_expired  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_time     <= w_time_nxt;
            r_done     <= w_done_nxt;
            r_load_err <= w_load_err_nxt;
            r_running  <= (w_state_nxt == S_RUN);
            r_expired  <= (w_state_nxt == S_EXPIRED);
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_reload <= 24'h0;
        else          r_reload <= w_reload_nxt;
    end
`endif

    assign o_time_out = r_time;
    assign o_running  = r_running;
    assign o_expired  = r_expired;
    assign o_done     = r_done;
    assign o_load_err = r_load_err;

endmodule

// File: tb/tb_countdown_timer_hms.sv
// Purpose : directed check of countdown_timer_hms (H24=1) with a queue of expected outputs.
// Latency : each step drives inputs, pushes the expected post-edge outputs, samples 1 time unit after the edge.
// Backpressure: none.
module tb_countdown_timer_hms;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        load = 1'b0;
    logic [23:0] load_time = 24'h0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] time_out;
    logic        running;
    logic        expired;
    logic        done;
    logic        load_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [23:0] t;
        logic        run;
        logic        expd;
        logic        done;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    countdown_timer_hms #(.H24(1'b1)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_tick      (tick),
        .i_load      (load),
        .i_load_time (load_time),
        .i_start     (start),
        .i_pause     (pause),
        .i_clear     (clear),
        .o_time_out  (time_out),
        .o_running   (running),
        .o_expired   (expired),
        .o_done      (done),
        .o_load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [23:0] et, input logic er, ee, ed, eerr);
        exp_t e;
        e.t = et; e.run = er; e.expd = ee; e.done = ed; e.err = eerr;
        sb_q.push_back(e);
    endtask

    // Pops the oldest expectation and compares it with the DUT outputs now.
    task automatic check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            cmp({tag, ".time"},    time_out,         e.t);
            cmp({tag, ".running"}, {23'h0, running}, {23'h0, e.run});
            cmp({tag, ".expired"}, {23'h0, expired}, {23'h0, e.expd});
            cmp({tag, ".done"},    {23'h0, done},    {23'h0, e.done});
            cmp({tag, ".lderr"},   {23'h0, load_err}, {23'h0, e.err});
        end
    endtask

    // Drive one cycle of inputs, record what the outputs must be after the edge, then check.
    task automatic step(input string tag, input logic tk, ld, input logic [23:0] lt,
                        input logic st, pa, cl,
                        input logic [23:0] et, input logic er, ee, ed, eerr);
        tick = tk; load = ld; load_time = lt; start = st; pause = pa; clear = cl;
        push(et, er, ee, ed, eerr);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        // Reset state
        #1;
        push(24'h0, 0, 0, 0, 0);
        check("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Expiry from 00:00:03
        step("ld3",    0, 1, 24'h000003, 0, 0, 0, 24'h000003, 0, 0, 0, 0);
        step("st3",    0, 0, 24'h0,      1, 0, 0, 24'h000003, 1, 0, 0, 0);
        step("tk3a",   1, 0, 24'h0,      0, 0, 0, 24'h000002, 1, 0, 0, 0);
        step("tk3b",   1, 0, 24'h0,      0, 0, 0, 24'h000001, 1, 0, 0, 0);
        step("tk3c",   1, 0, 24'h0,      0, 0, 0, AR ? 24'h000003 : 24'h0, AR, !AR, 1, 0);
        step("post3",  0, 0, 24'h0,      0, 0, 0, AR ? 24'h000003 : 24'h0, AR, !AR, 0, 0);
        step("tk3d",   1, 0, 24'h0,      0, 0, 0, AR ? 24'h000002 : 24'h0, AR, !AR, 0, 0);

        // Full borrow chain, pause dropping a tick, held pause/start
        step("ld10h",  0, 1, 24'h100000, 0, 0, 0, 24'h100000, 0, 0, 0, 0);
        step("st10h",  0, 0, 24'h0,      1, 0, 0, 24'h100000, 1, 0, 0, 0);
        step("borrow", 1, 0, 24'h0,      0, 0, 0, 24'h095959, 1, 0, 0, 0);
        step("pstick", 1, 0, 24'h0,      0, 1, 0, 24'h095959, 0, 0, 0, 0);
        step("phold",  1, 0, 24'h0,      0, 1, 0, 24'h095959, 0, 0, 0, 0);
        step("pidle",  1, 0, 24'h0,      0, 0, 0, 24'h095959, 0, 0, 0, 0);
        step("resume", 0, 0, 24'h0,      1, 0, 0, 24'h095959, 1, 0, 0, 0);
        step("tk58",   1, 0, 24'h0,      0, 0, 0, 24'h095958, 1, 0, 0, 0);
        step("sthold", 1, 0, 24'h0,      1, 0, 0, 24'h095958, 1, 0, 0, 0);
        step("mu_brw", 1, 0, 24'h0,      0, 0, 0, 24'h095957, 1, 0, 0, 0);

        // Load validation (state RUN must survive a rejected load)
        step("rej24",  0, 1, 24'h240000, 0, 0, 0, 24'h095957, 1, 0, 0, 1);
        step("errclr", 0, 0, 24'h0,      0, 0, 0, 24'h095957, 1, 0, 0, 0);
        step("ok2359", 0, 1, 24'h235959, 0, 0, 0, 24'h235959, 0, 0, 0, 0);
        step("rejm60", 0, 1, 24'h006000, 0, 0, 0, 24'h235959, 0, 0, 0, 1);
        step("rej0A",  0, 1, 24'h0A0000, 0, 0, 0, 24'h235959, 0, 0, 0, 1);
        step("rejs60", 0, 1, 24'h000060, 0, 0, 0, 24'h235959, 0, 0, 0, 1);
        step("ok1959", 0, 1, 24'h195959, 0, 0, 0, 24'h195959, 0, 0, 0, 0);

        // Start at zero is ignored; clear during RUN
        step("clr",    0, 0, 24'h0,      0, 0, 1, 24'h0,      0, 0, 0, 0);
        step("st0",    0, 0, 24'h0,      1, 0, 0, 24'h0,      0, 0, 0, 0);
        step("ld123",  0, 1, 24'h010203, 0, 0, 0, 24'h010203, 0, 0, 0, 0);
        step("st123",  0, 0, 24'h0,      1, 0, 0, 24'h010203, 1, 0, 0, 0);
        step("clrrun", 1, 0, 24'h0,      0, 0, 1, 24'h0,      0, 0, 0, 0);

        // Held load beats start and keeps the timer in IDLE
        step("ldhld1", 0, 1, 24'h000005, 1, 0, 0, 24'h000005, 0, 0, 0, 0);
        step("ldhld2", 1, 1, 24'h000005, 1, 0, 0, 24'h000005, 0, 0, 0, 0);

        // Async reset mid-RUN at 00:00:01 together with a tick
        step("ld1",    0, 1, 24'h000001, 0, 0, 0, 24'h000001, 0, 0, 0, 0);
        step("st1",    0, 0, 24'h0,      1, 0, 0, 24'h000001, 1, 0, 0, 0);
        tick = 1'b1;
        rst_n = 1'b0;
        #1;
        push(24'h0, 0, 0, 0, 0);
        check("arst_now");
        @(posedge clk);
        #1;
        push(24'h0, 0, 0, 0, 0);
        check("arst_hold");
        rst_n = 1'b1;
        step("arst_r1", 1, 0, 24'h0,     0, 0, 0, 24'h0,      0, 0, 0, 0);
        step("arst_r2", 0, 0, 24'h0,     0, 0, 0, 24'h0,      0, 0, 0, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Auto reload from 00:00:02
        step("ar_ld",  0, 1, 24'h000002, 0, 0, 0, 24'h000002, 0, 0, 0, 0);
        step("ar_st",  0, 0, 24'h0,      1, 0, 0, 24'h000002, 1, 0, 0, 0);
        step("ar_t1",  1, 0, 24'h0,      0, 0, 0, 24'h000001, 1, 0, 0, 0);
        step("ar_t2",  1, 0, 24'h0,      0, 0, 0, 24'h000002, 1, 0, 1, 0);
        step("ar_t3",  1, 0, 24'h0,      0, 0, 0, 24'h000001, 1, 0, 0, 0);
        step("ar_t4",  1, 0, 24'h0,      0, 0, 0, 24'h000002, 1, 0, 1, 0);
        step("ar_clr", 0, 0, 24'h0,      0, 0, 1, 24'h0,      0, 0, 0, 0);
`endif

        tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $error("FAIL sb_drain: %0d left, 0 required", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
